// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the core memory stage and an
// external debug/DMA port, with a starvation guard and contention counters.
module dmem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ready,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_count,
  output logic [15:0]   ext_xfer_count
);

  localparam logic [7:0]  LIMIT   = 8'(STARVE_LIMIT);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    OWN_CPU,
    OWN_EXT
  } owner_e;

  logic [7:0]    r_starve_cnt;
  logic          r_ext_rvalid;
  logic [DW-1:0] r_ext_rdata;
  logic [15:0]   r_stall_count;
  logic [15:0]   r_ext_xfer_count;

  logic   w_force;
  owner_e w_owner;
  logic   w_ext_ready;
  logic   w_cpu_stall;
  logic   w_xfer;
  logic   w_ext_read;

  // Ownership uses only cpu_req and registered state, so no ext_* input can
  // reach cpu_stall combinationally.
  always_comb begin
    w_force     = (r_starve_cnt == LIMIT);
    w_owner     = (cpu_req && !w_force) ? OWN_CPU : OWN_EXT;
    w_ext_ready = reset && (!cpu_req || w_force);
    w_cpu_stall = reset && cpu_req && w_force;
    w_xfer      = ext_req && w_ext_ready;
    w_ext_read  = w_xfer && !ext_we;
  end

  // NOTE: every output gets a default before the branches, so no latch is inferred.
  always_comb begin
    mem_addr  = ext_addr;
    mem_wdata = ext_wdata;
    mem_we    = ext_req && ext_we;
    if (w_owner == OWN_CPU) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end
    if (!reset) begin
      mem_we = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starve_cnt     <= '0;
      r_ext_rvalid     <= 1'b0;
      r_ext_rdata      <= '0;
      r_stall_count    <= '0;
      r_ext_xfer_count <= '0;
    end else begin
      if (w_xfer || !ext_req) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end

      r_ext_rvalid <= w_ext_read;
      if (w_ext_read) begin
        r_ext_rdata <= mem_rdata;
      end

      if (w_cpu_stall && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_xfer && (r_ext_xfer_count != CNT_MAX)) begin
        r_ext_xfer_count <= r_ext_xfer_count + 16'd1;
      end
    end
  end

  assign cpu_rdata      = mem_rdata;
  assign cpu_stall      = w_cpu_stall;
  assign ext_ready      = w_ext_ready;
  assign ext_rvalid     = r_ext_rvalid;
  assign ext_rdata      = r_ext_rdata;
  assign stall_count    = r_stall_count;
  assign ext_xfer_count = r_ext_xfer_count;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random
// traffic against a cycle-level reference model, and a counter saturation run.
module tb_dmem_port_arbiter;

  localparam int LIMIT     = 4;
  localparam int SAT_LIMIT = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr, ext_wdata;
  logic        mem_init;
  wire  [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  wire  [15:0] stall_count, ext_xfer_count;
  wire         cpu_stall, ext_ready, ext_rvalid, mem_we;

  dmem_port_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .stall_count(stall_count), .ext_xfer_count(ext_xfer_count)
  );

  // Second instance used only to drive the statistics counters into saturation.
  logic        s_reset, s_cpu_req, s_ext_req;
  logic [15:0] s_zero = 16'h0000;
  wire  [15:0] s_cpu_rdata, s_ext_rdata, s_mem_addr, s_mem_wdata, s_stall_count, s_xfer_count;
  wire         s_cpu_stall, s_ext_ready, s_ext_rvalid, s_mem_we;

  dmem_port_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(SAT_LIMIT)) dut_sat (
    .clk(clk), .reset(s_reset),
    .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_addr(s_zero), .cpu_wdata(s_zero),
    .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
    .ext_req(s_ext_req), .ext_we(1'b0), .ext_addr(s_zero), .ext_wdata(s_zero),
    .ext_ready(s_ext_ready), .ext_rvalid(s_ext_rvalid), .ext_rdata(s_ext_rdata),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we), .mem_rdata(s_zero),
    .stall_count(s_stall_count), .ext_xfer_count(s_xfer_count)
  );

  // Asynchronous-read data memory seen by the main instance.
  logic [15:0] tb_mem [0:65535];
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) tb_mem[i] <= 16'(i * 7 + 3);
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model state.
  logic [15:0] ref_mem [0:65535];
  int          m_wait;
  logic        m_rvalid;
  logic [15:0] m_rdata, m_stall_cnt, m_xfer_cnt;
  logic        obs_ready, obs_stall;

  int n_vec = 0;
  int n_err = 0;

  // One clock cycle: check combinational outputs mid-cycle, advance the model
  // at the edge, then check registered outputs just after it.
  task automatic run_cycle();
    logic        granted_ext, cpu_wins, e_ready, e_stall, e_we, xfer;
    logic [15:0] e_addr, e_wdata, e_rd;
    @(negedge clk);
    granted_ext = (m_wait == LIMIT);
    cpu_wins    = cpu_req && !granted_ext;
    e_ready     = reset && (!cpu_req || granted_ext);
    e_stall     = reset && cpu_req && granted_ext;
    e_addr      = cpu_wins ? cpu_addr  : ext_addr;
    e_wdata     = cpu_wins ? cpu_wdata : ext_wdata;
    e_we        = reset && (cpu_wins ? cpu_we : (ext_req && ext_we));
    obs_ready   = ext_ready;
    obs_stall   = cpu_stall;
    n_vec++;
    if (cpu_stall !== e_stall) begin
      n_err++; $display("FAIL cpu_stall: got %b expected %b at %0t", cpu_stall, e_stall, $time);
    end
    n_vec++;
    if (ext_ready !== e_ready) begin
      n_err++; $display("FAIL ext_ready: got %b expected %b at %0t", ext_ready, e_ready, $time);
    end
    n_vec++;
    if (mem_we !== e_we) begin
      n_err++; $display("FAIL mem_we: got %b expected %b at %0t", mem_we, e_we, $time);
    end
    if (reset) begin
      n_vec++;
      if (mem_addr !== e_addr) begin
        n_err++; $display("FAIL mem_addr: got %h expected %h at %0t", mem_addr, e_addr, $time);
      end
      n_vec++;
      if (mem_wdata !== e_wdata) begin
        n_err++; $display("FAIL mem_wdata: got %h expected %h at %0t", mem_wdata, e_wdata, $time);
      end
      n_vec++;
      if (cpu_rdata !== ref_mem[e_addr]) begin
        n_err++; $display("FAIL cpu_rdata: got %h expected %h at %0t", cpu_rdata, ref_mem[e_addr], $time);
      end
    end
    @(posedge clk);
    xfer = ext_req && e_ready;
    e_rd = ref_mem[ext_addr];
    if (!reset) begin
      m_wait = 0; m_rvalid = 1'b0; m_rdata = '0; m_stall_cnt = '0; m_xfer_cnt = '0;
    end else begin
      if (e_we) ref_mem[e_addr] = e_wdata;
      m_rvalid = xfer && !ext_we;
      if (m_rvalid) m_rdata = e_rd;
      m_wait = (xfer || !ext_req) ? 0 : m_wait + 1;
      if (e_stall && m_stall_cnt != 16'hFFFF) m_stall_cnt++;
      if (xfer && m_xfer_cnt != 16'hFFFF) m_xfer_cnt++;
    end
    #1;
    n_vec++;
    if (ext_rvalid !== m_rvalid) begin
      n_err++; $display("FAIL ext_rvalid: got %b expected %b at %0t", ext_rvalid, m_rvalid, $time);
    end
    n_vec++;
    if (ext_rdata !== m_rdata) begin
      n_err++; $display("FAIL ext_rdata: got %h expected %h at %0t", ext_rdata, m_rdata, $time);
    end
    n_vec++;
    if (stall_count !== m_stall_cnt) begin
      n_err++; $display("FAIL stall_count: got %h expected %h at %0t", stall_count, m_stall_cnt, $time);
    end
    n_vec++;
    if (ext_xfer_count !== m_xfer_cnt) begin
      n_err++; $display("FAIL ext_xfer_count: got %h expected %h at %0t", ext_xfer_count, m_xfer_cnt, $time);
    end
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    repeat (2) run_cycle();
    reset = 1;
  endtask

  task automatic set_ext(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    ext_req = 1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0005; cpu_wdata = 16'h1111;
    set_ext(1'b1, 16'h0006, 16'h2222);
    repeat (2) run_cycle();
    n_vec++;
    if (obs_ready !== 1'b0 || obs_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: ready/stall got %b/%b expected 0/0", obs_ready, obs_stall);
    end
    n_vec++;
    if (stall_count !== 16'h0 || ext_xfer_count !== 16'h0 || ext_rvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_state: counts %h/%h rvalid %b expected 0/0/0",
                        stall_count, ext_xfer_count, ext_rvalid);
    end
    idle();
    reset = 1;
  endtask

  task automatic test_ext_write_read();
    logic r1, r2;
    do_reset();
    set_ext(1'b1, 16'h0040, 16'hBEEF);
    run_cycle(); r1 = obs_ready;
    set_ext(1'b0, 16'h0040, 16'h0000);
    run_cycle(); r2 = obs_ready;
    n_vec++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== 16'hBEEF) begin
      n_err++; $display("FAIL ext_read_data: rvalid %b data %h expected 1 BEEF", ext_rvalid, ext_rdata);
    end
    idle();
    run_cycle();
    n_vec++;
    if (r1 !== 1'b1 || r2 !== 1'b1) begin
      n_err++; $display("FAIL ext_idle_ready: got %b%b expected 11", r1, r2);
    end
    n_vec++;
    if (ext_rvalid !== 1'b0 || ext_xfer_count !== 16'd2) begin
      n_err++; $display("FAIL ext_pulse_count: rvalid %b count %0d expected 0 2", ext_rvalid, ext_xfer_count);
    end
  endtask

  // Holds ext_req under continuous core loads; returns the cycle of acceptance.
  task automatic wait_accept(input int max_cycles, output int acc_cycle);
    acc_cycle = 0;
    for (int k = 1; k <= max_cycles && acc_cycle == 0; k++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100 + 16'($urandom_range(0, 15));
      run_cycle();
      if (obs_ready) begin
        acc_cycle = k;
        ext_req = 0;
      end
    end
  endtask

  task automatic test_starvation();
    int acc;
    do_reset();
    set_ext(1'b1, 16'h0010, 16'h1234);
    run_cycle();
    set_ext(1'b0, 16'h0010, 16'h0000);
    wait_accept(10, acc);
    n_vec++;
    if (acc !== 5) begin
      n_err++; $display("FAIL starve_grant_cycle: got %0d expected 5", acc);
    end
    n_vec++;
    if (obs_stall !== 1'b1 || ext_rvalid !== 1'b1 || ext_rdata !== 16'h1234) begin
      n_err++; $display("FAIL starve_read: stall %b rvalid %b data %h expected 1 1 1234",
                        obs_stall, ext_rvalid, ext_rdata);
    end
    run_cycle();
    n_vec++;
    if (obs_stall !== 1'b0 || stall_count !== 16'd1) begin
      n_err++; $display("FAIL starve_recover: stall %b count %0d expected 0 1", obs_stall, stall_count);
    end
    idle();
  endtask

  task automatic test_collision();
    int acc;
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h00AA;
    set_ext(1'b1, 16'h0020, 16'h00BB);
    run_cycle();
    n_vec++;
    if (tb_mem[16'h0020] !== 16'h00AA) begin
      n_err++; $display("FAIL collide_cpu_first: mem got %h expected 00AA", tb_mem[16'h0020]);
    end
    wait_accept(10, acc);
    n_vec++;
    if (acc !== 4 || tb_mem[16'h0020] !== 16'h00BB) begin
      n_err++; $display("FAIL collide_ext_later: extra cycles %0d mem %h expected 4 00BB",
                        acc, tb_mem[16'h0020]);
    end
    idle();
  endtask

  task automatic test_drop();
    int acc;
    do_reset();
    set_ext(1'b0, 16'h0050, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      cpu_req = 1; cpu_addr = 16'h0007;
      run_cycle();
      n_vec++;
      if (obs_ready !== 1'b0) begin
        n_err++; $display("FAIL drop_denied: ready got %b expected 0 in cycle %0d", obs_ready, k);
      end
    end
    ext_req = 0;
    run_cycle();
    set_ext(1'b0, 16'h0050, 16'h0000);
    wait_accept(10, acc);
    n_vec++;
    if (acc !== 5) begin
      n_err++; $display("FAIL drop_restart: grant cycle got %0d expected 5", acc);
    end
    idle();
  endtask

  task automatic test_reset_midread();
    do_reset();
    set_ext(1'b0, 16'h0040, 16'h0000);
    cpu_we = 1; cpu_addr = 16'h0060; cpu_wdata = 16'h5555;
    reset = 0;
    run_cycle();
    n_vec++;
    if (ext_rvalid !== 1'b0 || ext_xfer_count !== 16'd0) begin
      n_err++; $display("FAIL reset_accept: rvalid %b count %0d expected 0 0", ext_rvalid, ext_xfer_count);
    end
    reset = 1;
    cpu_we = 0;
    run_cycle();
    reset = 0;
    ext_req = 0;
    run_cycle();
    n_vec++;
    if (ext_rvalid !== 1'b0 || ext_xfer_count !== 16'd0 || stall_count !== 16'd0) begin
      n_err++; $display("FAIL reset_cancel: rvalid %b counts %0d/%0d expected 0 0/0",
                        ext_rvalid, ext_xfer_count, stall_count);
    end
    reset = 1;
    idle();
  endtask

  task automatic test_random();
    logic pend, was_reset;
    pend = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = 16'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        set_ext($urandom_range(0, 1), 16'($urandom_range(0, 15)), 16'($urandom));
      end else if (pend && $urandom_range(0, 39) == 0) begin
        pend = 0;
        ext_req = 0;
      end
      reset = ($urandom_range(0, 99) != 0);
      was_reset = !reset;
      run_cycle();
      if (pend && obs_ready && !was_reset) begin
        pend = 0;
        ext_req = 0;
      end
    end
    reset = 1;
    idle();
  endtask

  task automatic test_saturation();
    s_reset = 0; s_cpu_req = 1; s_ext_req = 1;
    repeat (2) @(posedge clk);
    #1 s_reset = 1;
    for (int i = 1; i <= 65540; i++) begin
      repeat (2) @(posedge clk);
      #1;
      if (i == 65534) begin
        n_vec++;
        if (s_stall_count !== 16'hFFFE) begin
          n_err++; $display("FAIL sat_before: got %h expected FFFE", s_stall_count);
        end
      end
      if (i == 65535) begin
        n_vec++;
        if (s_stall_count !== 16'hFFFF) begin
          n_err++; $display("FAIL sat_reach: got %h expected FFFF", s_stall_count);
        end
      end
    end
    n_vec++;
    if (s_stall_count !== 16'hFFFF || s_xfer_count !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_hold: stall %h xfer %h expected FFFF FFFF", s_stall_count, s_xfer_count);
    end
  endtask

  initial begin
    m_wait = 0; m_rvalid = 0; m_rdata = '0; m_stall_cnt = '0; m_xfer_cnt = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i * 7 + 3);
    s_reset = 0; s_cpu_req = 0; s_ext_req = 0;
    idle();
    reset = 0;
    mem_init = 1;
    @(posedge clk);
    #1 mem_init = 0;
    fork
      begin
        test_reset();
        test_ext_write_read();
        test_starvation();
        test_collision();
        test_drop();
        test_reset_midread();
        test_random();
      end
      test_saturation();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
